// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-outstanding memory port between the fetch
//               and data-access requesters of a 5-stage MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_valid,
  output logic              stall_inst,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  input  logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_valid,
  output logic              stall_data,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    WAIT_I = 3'd2,
    REQ_D  = 3'd3,
    WAIT_D = 3'd4
  } state_e;

  localparam logic [3:0] c_starve_lim = 4'(STARVE_LIM);

  state_e            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              fetch_starved;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
    end
  end

  // Fetch only overrides data priority once it has lost STARVE_LIM times in a row
  assign fetch_starved = inst_req && (starve_cnt_q == c_starve_lim);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    inst_valid   = 1'b0;
    data_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_req && !fetch_starved) begin
          state_d     = REQ_D;
          mem_req_d   = 1'b1;
          mem_wr_d    = data_wr;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          mem_wstrb_d = data_wr ? data_wstrb : 4'd0;
          if (inst_req && (starve_cnt_q < c_starve_lim)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else if (inst_req) begin
          state_d      = REQ_I;
          starve_cnt_d = 4'd0;
          mem_req_d    = 1'b1;
          mem_wr_d     = 1'b0;
          mem_addr_d   = inst_addr;
          mem_wdata_d  = '0;
          mem_wstrb_d  = 4'd0;
        end
      end
      REQ_I: begin
        if (mem_gnt) begin
          state_d   = WAIT_I;
          mem_req_d = 1'b0;
        end
      end
      WAIT_I: begin
        if (mem_rvalid) begin
          inst_valid = 1'b1;
          state_d    = IDLE;
        end
      end
      REQ_D: begin
        if (mem_gnt) begin
          state_d   = WAIT_D;
          mem_req_d = 1'b0;
        end
      end
      WAIT_D: begin
        if (mem_rvalid) begin
          data_valid = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign inst_rdata = inst_valid ? mem_rdata : '0;
  assign data_rdata = data_valid ? mem_rdata : '0;
  assign stall_inst = inst_req & ~inst_valid;
  assign stall_data = data_req & ~data_valid;

  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a scoreboard of
//               expected read data per requester.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_valid;
  logic        stall_inst;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        stall_data;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          resp_en  = 1'b0;
  int          gnt_dly  = 0;
  int          rv_dly   = 1;
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  int          ord_q[$];
  int          vcyc_q[$];

  mem_port_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_LIM(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_rdata(inst_rdata),
    .inst_valid(inst_valid),
    .stall_inst(stall_inst),
    .data_req  (data_req),
    .data_wr   (data_wr),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_wstrb(data_wstrb),
    .data_rdata(data_rdata),
    .data_valid(data_valid),
    .stall_data(stall_data),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Memory model: grants gnt_dly cycles after mem_req rises, responds rv_dly cycles after grant
  initial begin : responder
    int          rp;
    int          rc;
    logic [31:0] ra;
    rp = 0; rc = 0; ra = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!resp_en) begin
        rp = 0; rc = 0;
      end else begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        if (rst) begin
          rp = 0; rc = 0;
        end else if (rp == 0) begin
          if (mem_req) begin
            if (rc == gnt_dly) begin
              mem_gnt = 1'b1; ra = mem_addr; rp = 1; rc = 0;
            end else begin
              rc++;
            end
          end
        end else begin
          rc++;
          if (rc == rv_dly) begin
            mem_rvalid = 1'b1; mem_rdata = rdata_of(ra); rp = 0; rc = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset(input bit en);
    @(posedge clk); #1;
    resp_en = en;
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
    if (!en) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    end
    exp_i_q.delete(); exp_d_q.delete(); ord_q.delete(); vcyc_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_inst(input logic [31:0] a);
    int          n;
    logic [31:0] e;
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = a;
    exp_i_q.push_back(rdata_of(a));
    n = 0;
    do begin @(negedge clk); n++; end while (!inst_valid && n < 60);
    n_checks++;
    if (!inst_valid) begin
      n_fail++;
      $display("FAIL inst_timeout: inst_valid=0 after %0d cycles, required 1", n);
      void'(exp_i_q.pop_front());
    end else begin
      e = exp_i_q.pop_front();
      n_checks++;
      if (inst_rdata !== e) begin
        n_fail++;
        $display("FAIL inst_rdata: got %h, required %h", inst_rdata, e);
      end
      ord_q.push_back(0);
      vcyc_q.push_back(cyc);
    end
  endtask

  task automatic do_data(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                         input logic [3:0] ws);
    int          n;
    logic [31:0] e;
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = wr; data_addr = a; data_wdata = wd; data_wstrb = ws;
    exp_d_q.push_back(rdata_of(a));
    n = 0;
    do begin @(negedge clk); n++; end while (!data_valid && n < 60);
    n_checks++;
    if (!data_valid) begin
      n_fail++;
      $display("FAIL data_timeout: data_valid=0 after %0d cycles, required 1", n);
      void'(exp_d_q.pop_front());
    end else begin
      e = exp_d_q.pop_front();
      n_checks++;
      if (data_rdata !== e) begin
        n_fail++;
        $display("FAIL data_rdata: got %h, required %h", data_rdata, e);
      end
      ord_q.push_back(1);
      vcyc_q.push_back(cyc);
    end
  endtask

  task automatic drop_inst();
    @(posedge clk); #1 inst_req = 1'b0;
  endtask

  task automatic drop_data();
    @(posedge clk); #1 data_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: req=%b wr=%b addr=%h wdata=%h wstrb=%b, required all 0",
               mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb);
    end
    n_checks++;
    if ({inst_valid, data_valid, stall_inst, stall_data} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outs: iv=%b dv=%b si=%b sd=%b, required 0000",
               inst_valid, data_valid, stall_inst, stall_data);
    end
  endtask

  task automatic test_fetch();
    do_reset(1'b0);
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    @(negedge clk);
    n_checks++;
    if ({stall_inst, inst_valid, mem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL fetch_c1: stall/valid/req=%b, required 100", {stall_inst, inst_valid, mem_req});
    end
    @(posedge clk); #1 mem_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_wr, mem_wstrb, stall_inst, inst_valid} !== 8'b1_0_0000_1_0) begin
      n_fail++;
      $display("FAIL fetch_c2: req/wr/wstrb/stall/valid=%b, required 10000010",
               {mem_req, mem_wr, mem_wstrb, stall_inst, inst_valid});
    end
    n_checks++;
    if (mem_addr !== 32'hBFC0_0000) begin
      n_fail++;
      $display("FAIL fetch_addr: got %h, required bfc00000", mem_addr);
    end
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2408_0005;
    @(negedge clk);
    n_checks++;
    if ({inst_valid, stall_inst, mem_req, data_valid} !== 4'b1000 || inst_rdata !== 32'h2408_0005) begin
      n_fail++;
      $display("FAIL fetch_c3: valid/stall/req/dvalid=%b rdata=%h, required 1000 24080005",
               {inst_valid, stall_inst, mem_req, data_valid}, inst_rdata);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0; inst_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({inst_valid, inst_rdata} !== '0) begin
      n_fail++;
      $display("FAIL fetch_c4: valid=%b rdata=%h, required 0 0", inst_valid, inst_rdata);
    end
  endtask

  task automatic test_store_latency();
    do_reset(1'b1);
    gnt_dly = 2; rv_dly = 3;
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_0010;
    data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (mem_req !== (c >= 2 && c <= 4)) begin
        n_fail++;
        $display("FAIL store_req c%0d: got %b, required %b", c, mem_req, (c >= 2 && c <= 4));
      end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'b0011 || mem_wr !== 1'b1) begin
          n_fail++;
          $display("FAIL store_fields c%0d: addr=%h wdata=%h wstrb=%b wr=%b, required 10 deadbeef 0011 1",
                   c, mem_addr, mem_wdata, mem_wstrb, mem_wr);
        end
      end
      n_checks++;
      if (data_valid !== (c == 7) || stall_data !== (c <= 6)) begin
        n_fail++;
        $display("FAIL store_valid c%0d: valid=%b stall=%b, required %b %b",
                 c, data_valid, stall_data, (c == 7), (c <= 6));
      end
      if (c == 7) begin
        n_checks++;
        if (data_rdata !== rdata_of(32'h10)) begin
          n_fail++;
          $display("FAIL store_rdata: got %h, required %h", data_rdata, rdata_of(32'h10));
        end
      end
      @(posedge clk); #1;
      if (c == 7) data_req = 1'b0;
    end
    gnt_dly = 0; rv_dly = 1;
  endtask

  task automatic test_load_strb();
    int n;
    do_reset(1'b1);
    gnt_dly = 1; rv_dly = 1;
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0040;
    data_wdata = 32'h1234_5678; data_wstrb = 4'b1111;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req && n < 10);
    n_checks++;
    if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_wstrb !== 4'b0000 || mem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL load_fields: req=%b wr=%b wstrb=%b addr=%h, required 1 0 0000 40",
               mem_req, mem_wr, mem_wstrb, mem_addr);
    end
    n = 0;
    while (!data_valid && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (data_valid !== 1'b1 || data_rdata !== rdata_of(32'h40)) begin
      n_fail++;
      $display("FAIL load_rdata: valid=%b rdata=%h, required 1 %h", data_valid, data_rdata, rdata_of(32'h40));
    end
    drop_data();
    gnt_dly = 0;
  endtask

  task automatic test_starvation();
    int exp_ord[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    do_reset(1'b1);
    gnt_dly = 0; rv_dly = 1;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          do_data(32'h0000_0100 + 32'(k * 4), k[0], 32'hA000_0000 + 32'(k), 4'b1111);
        end
        drop_data();
      end
      begin
        for (int j = 0; j < 2; j++) begin
          do_inst(32'hBFC0_0100 + 32'(j * 4));
        end
        drop_inst();
      end
    join
    n_checks++;
    if (ord_q.size() != 10) begin
      n_fail++;
      $display("FAIL starve_count: got %0d completions, required 10", ord_q.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        n_checks++;
        if (ord_q[k] != exp_ord[k]) begin
          n_fail++;
          $display("FAIL starve_order[%0d]: got %0d, required %0d (1=data 0=fetch)", k, ord_q[k], exp_ord[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    gnt_dly = 0; rv_dly = 1;
    fork
      begin do_data(32'h0000_0200, 1'b0, '0, 4'b0000); drop_data(); end
      begin do_inst(32'hBFC0_0200); drop_inst(); end
    join
    n_checks++;
    if (ord_q.size() != 2 || vcyc_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d completions, required 2", ord_q.size());
    end else begin
      n_checks++;
      if (ord_q[0] != 1 || ord_q[1] != 0) begin
        n_fail++;
        $display("FAIL b2b_order: got %0d,%0d, required 1,0", ord_q[0], ord_q[1]);
      end
      n_checks++;
      if (vcyc_q[1] - vcyc_q[0] != 3) begin
        n_fail++;
        $display("FAIL b2b_gap: got %0d cycles, required 3", vcyc_q[1] - vcyc_q[0]);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset(1'b0);
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_0080;
    data_wdata = 32'h0BAD_F00D; data_wstrb = 4'b1100;
    @(posedge clk); #1 mem_gnt = 1'b1;
    @(posedge clk); #1 mem_gnt = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_req, data_valid, stall_data} !== 3'b001 || mem_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL wait_d: req/valid/stall=%b addr=%h, required 001 80",
               {mem_req, data_valid, stall_data}, mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b1; data_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_checks++;
    if ({mem_req, data_valid, inst_valid} !== 3'b000 || mem_addr !== '0 || mem_wstrb !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_wait: req/dv/iv=%b addr=%h wstrb=%b, required 000 0 0000",
               {mem_req, data_valid, inst_valid}, mem_addr, mem_wstrb);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0084;
    @(posedge clk); #1 mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    n_checks++;
    if (data_valid !== 1'b1 || data_rdata !== 32'h1357_9BDF) begin
      n_fail++;
      $display("FAIL rst_recover: valid=%b rdata=%h, required 1 13579bdf", data_valid, data_rdata);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0; data_req = 1'b0;
  endtask

  task automatic test_spurious_rvalid();
    do_reset(1'b0);
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0001;
    @(negedge clk);
    n_checks++;
    if ({inst_valid, stall_inst} !== 2'b01) begin
      n_fail++;
      $display("FAIL spur_idle: valid/stall=%b, required 01", {inst_valid, stall_inst});
    end
    @(posedge clk); #1 mem_rdata = 32'hAAAA_0002;
    @(negedge clk);
    n_checks++;
    if ({inst_valid, mem_req, stall_inst} !== 3'b011) begin
      n_fail++;
      $display("FAIL spur_req: valid/req/stall=%b, required 011", {inst_valid, mem_req, stall_inst});
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_gnt: valid=%b, required 0", inst_valid);
    end
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8C08_0004;
    @(negedge clk);
    n_checks++;
    if (inst_valid !== 1'b1 || inst_rdata !== 32'h8C08_0004) begin
      n_fail++;
      $display("FAIL spur_resp: valid=%b rdata=%h, required 1 8c080004", inst_valid, inst_rdata);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0; inst_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
    test_reset();
    test_fetch();
    test_store_latency();
    test_load_strb();
    test_starvation();
    test_back_to_back();
    test_reset_in_wait();
    test_spurious_rvalid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
